// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery domain conversion blocks.
// Both the into-Montgomery and out-of-Montgomery converters use these.
package mont_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int LEN_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOOP = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mont_state_t;

endpackage

// File: rtl/mont_cond_sub.sv
// Conditional subtract: o_y = (i_a >= i_n) ? i_a - i_n : i_a.
// Final range fix after a Montgomery reduction; reusable by other blocks.
module mont_cond_sub #(
   parameter int W = 33
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_n,
   output logic [W-1:0] o_y
);

   assign o_y = (i_a >= i_n) ? (i_a - i_n) : i_a;

endmodule

// File: rtl/mont_to_norm.sv
// Converts a Montgomery-domain value back to normal form: md_out = num_in * 2^-len mod N.
// One halving step per LOOP cycle, then a single conditional subtract in FIX.
module mont_to_norm
   import mont_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              md_start,
   input  logic [LEN_W-1:0]  len,
   input  logic [DATA_W-1:0] num_in,
   input  logic [DATA_W-1:0] modulus,
   output logic              md_end,
   output logic [DATA_W-1:0] md_out,
   output logic              busy,
   output logic              err
);

   localparam int AW = DATA_W + 1;

   mont_state_t       r_state;
   logic [AW-1:0]     r_acc;
   logic [DATA_W-1:0] r_mod;
   logic [LEN_W-1:0]  r_cnt;
   logic              r_end;
   logic              r_busy;
   logic              r_err;
   logic [DATA_W-1:0] r_out;

   logic [AW-1:0]     w_modExt;
   logic [AW-1:0]     w_half;
   logic [AW-1:0]     w_fixed;

   assign w_modExt = {1'b0, r_mod};

   // The extra accumulator bit keeps the carry of acc + N before the halving shift.
   assign w_half = (r_acc + (r_acc[0] ? w_modExt : '0)) >> 1;

   mont_cond_sub #(
      .W (AW)
   ) u_condSub (
      .i_a (r_acc),
      .i_n (w_modExt),
      .o_y (w_fixed)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_mod   <= '0;
         r_cnt   <= '0;
         r_end   <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_out   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_end <= 1'b0;
               // A start during the md_end cycle is still inside busy, so it is dropped.
               if (md_start && !r_busy) begin
                  r_acc  <= {1'b0, num_in};
                  r_mod  <= modulus;
                  r_cnt  <= len;
                  r_busy <= 1'b1;
                  if (!modulus[0]) begin
                     r_state <= DONE;
                  end else if (len == '0) begin
                     r_state <= FIX;
                  end else begin
                     r_state <= LOOP;
                  end
               end else begin
                  r_busy <= 1'b0;
               end
            end
            LOOP: begin
               r_acc <= w_half;
               r_cnt <= r_cnt - LEN_W'(1);
               if (r_cnt == LEN_W'(1)) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               r_acc   <= w_fixed;
               r_state <= DONE;
            end
            DONE: begin
               r_end   <= 1'b1;
               r_out   <= r_mod[0] ? r_acc[DATA_W-1:0] : '0;
               r_err   <= ~r_mod[0];
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign md_end = r_end;
   assign md_out = r_out;
   assign busy   = r_busy;
   assign err    = r_err;

endmodule

// File: tb/tb_mont_to_norm.sv
// Self-checking bench for mont_to_norm: scoreboard of expected results with start edges,
// compared against each md_end pulse, including error, reset-abort and busy-ignore cases.
module tb_mont_to_norm;

   typedef struct {
      logic [31:0] out;
      logic        err;
      int          startEdge;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        md_start;
   logic [7:0]  len;
   logic [31:0] num_in;
   logic [31:0] modulus;
   logic        md_end;
   logic [31:0] md_out;
   logic        busy;
   logic        err;

   int   checkCount;
   int   errorCount;
   int   edgeCount;
   exp_t sb[$];

   mont_to_norm #(
      .DATA_W (32),
      .LEN_W  (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .md_start (md_start),
      .len      (len),
      .num_in   (num_in),
      .modulus  (modulus),
      .md_end   (md_end),
      .md_out   (md_out),
      .busy     (busy),
      .err      (err)
   );

   // Free-running clock and a count of rising edges used to measure latency.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edgeCount++;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference by exhaustive search: the y in [0,N) with y*2^l == x (mod N).
   function automatic logic [31:0] refNorm(input longint x, input int l, input longint n);
      for (longint y = 0; y < n; y++) begin
         if (((y << l) % n) == (x % n)) return y[31:0];
      end
      return 32'd0;
   endfunction

   // Every md_end is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (md_end) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_md_end", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("md_out", 64'(md_out), 64'(e.out));
            checkOutput("err", 64'(err), 64'(e.err));
            checkOutput("latency", 64'(edgeCount - e.startEdge), 64'(e.lat));
            checkOutput("busy_at_end", 64'(busy), 64'd1);
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] x, input logic [7:0] l, input logic [31:0] n,
                                input logic [31:0] expOut);
      exp_t e;
      @(negedge clk);
      #1;
      num_in   = x;
      len      = l;
      modulus  = n;
      md_start = 1'b1;
      e.out       = n[0] ? expOut : 32'd0;
      e.err       = ~n[0];
      e.startEdge = edgeCount + 1;
      e.lat       = n[0] ? int'(l) + 2 : 1;
      sb.push_back(e);
      @(negedge clk);
      #1;
      md_start = 1'b0;
   endtask

   task automatic waitDone(input int maxCycles);
      for (int i = 0; i < maxCycles && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checkOutput("timeout_pending", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      edgeCount  = 0;
      rst        = 1'b1;
      md_start   = 1'b0;
      len        = '0;
      num_in     = '0;
      modulus    = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset_md_end", 64'(md_end), 64'd0);
      checkOutput("reset_md_out", 64'(md_out), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_err", 64'(err), 64'd0);
      #1;
      rst = 1'b0;

      // Basic vector; busy must rise the cycle after acceptance.
      applyStimulus(32'd5, 8'd4, 32'd13, 32'd6);
      checkOutput("busy_after_start", 64'(busy), 64'd1);
      waitDone(50);
      checkOutput("busy_idle", 64'(busy), 64'd0);

      applyStimulus(32'd7, 8'd0, 32'd13, 32'd7);
      waitDone(50);

      applyStimulus(32'd1, 8'd32, 32'hFFFF_FFFB, 32'hCCCC_CCC9);
      waitDone(100);

      applyStimulus(32'd9, 8'd4, 32'd12, 32'd0);
      waitDone(50);
      applyStimulus(32'd9, 8'd4, 32'd0, 32'd0);
      waitDone(50);

      // A second start while busy must be ignored: result and latency stay those of the first.
      applyStimulus(32'd5, 8'd4, 32'd13, 32'd6);
      @(negedge clk);
      #1;
      num_in   = 32'd1;
      len      = 8'd0;
      modulus  = 32'd12;
      md_start = 1'b1;
      @(negedge clk);
      #1;
      md_start = 1'b0;
      waitDone(50);

      // Reset in the middle of LOOP aborts without an md_end.
      applyStimulus(32'd5, 8'd4, 32'd13, 32'd6);
      @(negedge clk);
      #1;
      rst      = 1'b1;
      md_start = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      checkOutput("abort_md_end", 64'(md_end), 64'd0);
      checkOutput("abort_md_out", 64'(md_out), 64'd0);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_err", 64'(err), 64'd0);
      #1;
      rst      = 1'b0;
      md_start = 1'b0;
      repeat (10) @(negedge clk);
      applyStimulus(32'd5, 8'd4, 32'd13, 32'd6);
      waitDone(50);

      // Random small odd moduli with in-range operands.
      for (int t = 0; t < 20; t++) begin
         longint n, x;
         int     l;
         n = 2 * longint'($urandom_range(0, 127)) + 1;
         l = int'($urandom_range(0, 8));
         x = longint'($urandom_range(0, 32'(n * (64'd1 << l) - 1)));
         applyStimulus(x[31:0], 8'(l), n[31:0], refNorm(x, l, n));
         waitDone(50);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      checkOutput("global_timeout", 64'd1, 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/mont_to_norm.md
MONT_TO_NORM -- requirements
Module: mont_to_norm

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width.
REQ-002 Parameter LEN_W, default 8, width of the len exponent.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 md_start  input  1  one-cycle start pulse; sampled only in IDLE.
REQ-006 len  input  LEN_W  exponent of R = 2^len; range 0..255.
REQ-007 num_in  input  DATA_W  Montgomery-domain value x.
REQ-008 modulus  input  DATA_W  modulus N; must be odd and nonzero.
REQ-009 md_end  output  1  one-cycle done pulse.
REQ-010 md_out  output  DATA_W  result (x * 2^-len) mod N; valid from md_end, held until next accepted start.
REQ-011 busy  output  1  high from the cycle after start acceptance until the md_end cycle, inclusive.
REQ-012 err  output  1  high with md_end when modulus is even or zero; held with md_out.

Function
REQ-013 The block SHALL be the inverse of the existing into-Montgomery conversion: md_out = num_in * R^-1 mod N, R = 2^len.
REQ-014 FSM states: IDLE, LOOP, FIX, DONE.
REQ-015 IDLE with md_start=1: latch num_in into a DATA_W+1 accumulator; latch modulus; load counter with len.
REQ-016 IDLE transitions: modulus[0]=0 -> DONE; len=0 -> FIX; otherwise -> LOOP.
REQ-017 Each LOOP cycle: acc <= (acc + (acc[0] ? N : 0)) >> 1, evaluated at DATA_W+1 bits so no carry is lost; counter decrements.
REQ-018 LOOP -> FIX on the cycle the counter reaches 0, after exactly len iterations.
REQ-019 FIX: if acc >= N then acc <= acc - N; single conditional subtract; -> DONE.
REQ-020 DONE: md_end=1 for one cycle; md_out <= acc[DATA_W-1:0], err=0; -> IDLE.
REQ-021 Even/zero modulus path: md_out=0, err=1, md_end at start edge +1.
REQ-022 Latency: with start sampled at edge k, md_end is high after edge k+len+2.
REQ-023 md_start while busy SHALL be ignored; inputs are not re-sampled.
REQ-024 Result SHALL be exact for num_in < N*2^len; other inputs are out of range and their result is unspecified but md_end still fires.
REQ-025 Counter width LEN_W; no wrap-around occurs because it stops at 0.

Reset
REQ-026 rst=1 at any edge, including mid-LOOP or FIX: state <= IDLE; md_end, md_out, busy, err, acc, counter <= 0.
REQ-027 rst has priority over md_start in the same cycle; no md_end is produced for an aborted operation.

Structure
REQ-028 Shared package mont_pkg SHALL hold DATA_W/LEN_W defaults and the FSM state enum; it is shared with the into-Montgomery block.
REQ-029 One sub-module, mont_cond_sub (conditional subtract acc >= N ? acc-N : acc), SHALL be used in FIX and is reusable elsewhere.

Verification
REQ-030 N=13, len=4, num_in=5 -> md_out=6, err=0, md_end at k+6.
REQ-031 Round trip: the into-Montgomery block's output for (6, len=4, N=13) is 5; feeding 5 here gives 6.
REQ-032 N=0xFFFFFFFB, len=32, num_in=1 -> md_out=0xCCCCCCC9 (3435973833), exercising 33-bit carry; md_end at k+34.
REQ-033 len=0, N=13, num_in=7 -> md_out=7, md_end at k+2.
REQ-034 N=12 -> err=1, md_out=0, md_end at k+1; a second md_start during a busy run is ignored.
REQ-035 rst pulsed during LOOP of REQ-030 -> outputs 0 next cycle, no md_end; a new start then completes correctly.
